// File: rtl/alu_pkg.sv
// Shared types for the alu_pipe execute unit: opcodes, FSM states and the flag record.
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_NAND = 3'b010,
    ALU_XOR  = 3'b011,
    ALU_SLL  = 3'b100,
    ALU_SRA  = 3'b101,
    ALU_ROR  = 3'b110,
    ALU_ILL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } alu_flags_t;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRA) || (op == ALU_ROR);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: iterative one-bit-per-cycle SLL/SRA/ROR engine with a down-counter.
// Latency: shamt cycles after start; no backpressure, the owning FSM collects result_o when done_o.
// result_o is the value after the step taken this cycle; done_o marks the final step.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  alu_op_e          mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [SHW-1:0]   shamt_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] data_q;
  logic [SHW-1:0]   cnt_q;
  alu_op_e          mode_q;
  logic [WIDTH-1:0] step;

  always_comb begin
    step = data_q;
    case (mode_q)
      ALU_SLL: step = {data_q[WIDTH-2:0], 1'b0};
      ALU_SRA: step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      ALU_ROR: step = {data_q[0], data_q[WIDTH-1:1]};
      default: step = data_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      mode_q <= ALU_SLL;
    end else if (start_i) begin
      data_q <= data_i;
      cnt_q  <= shamt_i;
      mode_q <= mode_i;
    end else if (cnt_q != '0) begin
      data_q <= step;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign done_o   = (cnt_q == {{(SHW-1){1'b0}}, 1'b1});
  assign result_o = step;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: WIDTH-bit execute unit with Z/V/N flags; ALU_SAT_EN selects saturating ADD/SUB.
// Latency: 1 cycle for logic/arith (and zero-amount shifts), 1+shamt cycles for shifts.
// Backpressure: result held in HOLD until out_ready; in_ready low while shifting or stalled.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  alu_op_e          op_q, op_d;
  alu_flags_t       flags_q, flags_d;

  alu_op_e          op_in;
  logic [SHW-1:0]   shamt;
  logic             accept, fire_out, sh_start, sh_done;
  logic [WIDTH-1:0] sh_result;
  logic [WIDTH-1:0] b_eff, sum, comb_res;
  logic             is_sub, ovf, comb_err;

  assign op_in    = alu_op_e'(in_op);
  assign shamt    = in_b[SHW-1:0];
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign fire_out = (state_q == HOLD) && out_ready;
  assign sh_start = accept && is_shift(op_in) && (shamt != '0);

  // SUB is A + ~B + 1, so one overflow rule covers both arithmetic ops.
  always_comb begin
    is_sub   = (op_in == ALU_SUB);
    b_eff    = is_sub ? ~in_b : in_b;
    sum      = in_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    ovf      = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    comb_res = '0;
    comb_err = 1'b0;
    case (op_in)
      ALU_ADD, ALU_SUB: begin
`ifdef ALU_SAT_EN
        if (ovf) comb_res = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else     comb_res = sum;
        comb_err = 1'b0;
`else
        comb_res = sum;
        comb_err = ovf;
`endif
      end
      ALU_NAND: comb_res = ~(in_a & in_b);
      ALU_XOR:  comb_res = in_a ^ in_b;
      ALU_SLL, ALU_SRA, ALU_ROR: comb_res = in_a;
      default: begin
        comb_res = '0;
        comb_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    flags_d = flags_q;

    if (fire_out) begin
      state_d = IDLE;
      if (op_q != ALU_ILL) flags_d.z = (res_q == '0);
      if ((op_q == ALU_ADD) || (op_q == ALU_SUB)) begin
        flags_d.v = ovf_q;
        flags_d.n = res_q[WIDTH-1];
      end
    end

    if ((state_q == SHIFT) && sh_done) begin
      state_d = HOLD;
      res_d   = sh_result;
      err_d   = 1'b0;
    end

    if (accept) begin
      op_d  = op_in;
      ovf_d = ((op_in == ALU_ADD) || (op_in == ALU_SUB)) && ovf;
      if (sh_start) begin
        state_d = SHIFT;
      end else begin
        state_d = HOLD;
        res_d   = comb_res;
        err_d   = comb_err;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      op_q    <= ALU_ADD;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      flags_q <= flags_d;
    end
  end

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .start_i  (sh_start),
    .mode_i   (op_in),
    .data_i   (in_a),
    .shamt_i  (shamt),
    .done_o   (sh_done),
    .result_o (sh_result)
  );

  assign out_valid  = (state_q == HOLD);
  assign out_result = res_q;
  assign out_error  = err_q;
  assign flag_z     = flags_q.z;
  assign flag_v     = flags_q.v;
  assign flag_n     = flags_q.n;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=16; inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [2:0]  in_op;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic        out_error, flag_z, flag_v, flag_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_error  (out_error),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for exactly one cycle; caller guarantees in_ready is high.
  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
    in_op    = 3'b011;
    in_a     = 16'hDEAD;
    in_b     = 16'hBEEF;
  endtask

  // Counts negedges after the accept until out_valid; expiry is a failed check.
  task automatic wait_valid(output int n);
    logic seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n = i;
      end else begin
        tick();
      end
    end
    if (!seen) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int stale;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_error", out_error, 0);
    chk("rst_flags", {flag_z, flag_v, flag_n}, 3'b000);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    // 1. ADD overflow
    tick();
    issue(3'b000, 16'h7FFF, 16'h0001);
    @(negedge clk);
    chk("add_valid", out_valid, 1);
`ifdef ALU_SAT_EN
    chk("add_result", out_result, 16'h7FFF);
    chk("add_error", out_error, 0);
`else
    chk("add_result", out_result, 16'h8000);
    chk("add_error", out_error, 1);
`endif
    chk("add_flags_before_hs", {flag_z, flag_v, flag_n}, 3'b000);
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("add_valid_after_hs", out_valid, 0);
`ifdef ALU_SAT_EN
    chk("add_flags", {flag_z, flag_v, flag_n}, 3'b010);
`else
    chk("add_flags", {flag_z, flag_v, flag_n}, 3'b011);
`endif

    // 2. SRA 0x8000 by 4: valid at t+5, busy t+1..t+4
    tick();
    issue(3'b101, 16'h8000, 16'h0004);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("sra_busy_in_ready", in_ready, 0);
      chk("sra_busy_valid", out_valid, 0);
      tick();
    end
    @(negedge clk);
    chk("sra_valid_t5", out_valid, 1);
    chk("sra_result", out_result, 16'hF800);
    chk("sra_error", out_error, 0);
    tick();
    @(negedge clk);
`ifdef ALU_SAT_EN
    chk("sra_flags", {flag_z, flag_v, flag_n}, 3'b010);
`else
    chk("sra_flags", {flag_z, flag_v, flag_n}, 3'b011);
`endif

    // 3. XOR stalled 3 cycles
    out_ready = 1'b0;
    tick();
    issue(3'b011, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("xor_hold_valid", out_valid, 1);
      chk("xor_hold_result", out_result, 16'h0FF0);
      chk("xor_hold_in_ready", in_ready, 0);
      chk("xor_hold_z", flag_z, 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("xor_in_ready_on_hs", in_ready, 1);
    tick();
    @(negedge clk);
    chk("xor_after_valid", out_valid, 0);
    chk("xor_after_z", flag_z, 0);

    // 4. NAND then SUB back-to-back
    tick();
    in_valid = 1'b1; in_op = 3'b010; in_a = 16'hFFFF; in_b = 16'hFFFF;
    tick();
    in_op = 3'b001; in_a = 16'h0005; in_b = 16'h0005;
    @(negedge clk);
    chk("nand_valid", out_valid, 1);
    chk("nand_result", out_result, 16'h0000);
    chk("nand_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub_valid", out_valid, 1);
    chk("sub_result", out_result, 16'h0000);
    chk("sub_error", out_error, 0);
    chk("nand_z", flag_z, 1);
    tick();
    @(negedge clk);
    chk("sub_flags", {flag_z, flag_v, flag_n}, 3'b100);

    // 6. Illegal op with Z=1
    tick();
    issue(3'b111, 16'h1234, 16'h0005);
    @(negedge clk);
    chk("ill_result", out_result, 16'h0000);
    chk("ill_error", out_error, 1);
    tick();
    @(negedge clk);
    chk("ill_flags", {flag_z, flag_v, flag_n}, 3'b100);

    // Zero-amount shift completes in one cycle; single-step rotate in two
    tick();
    issue(3'b100, 16'h00F1, 16'h0010);
    wait_valid(lat);
    chk("sll0_latency", lat, 1);
    chk("sll0_result", out_result, 16'h00F1);
    tick();
    issue(3'b110, 16'h0003, 16'h0001);
    wait_valid(lat);
    chk("ror1_latency", lat, 2);
    chk("ror1_result", out_result, 16'h8001);
    tick();
    issue(3'b100, 16'h0001, 16'h000F);
    wait_valid(lat);
    chk("sll15_latency", lat, 16);
    chk("sll15_result", out_result, 16'h8000);
    tick();
    @(negedge clk);
    chk("sll15_z", flag_z, 0);

    // Set Z=1 so the reset below has a flag to clear
    tick();
    issue(3'b001, 16'h0009, 16'h0009);
    tick();

    // 5. ROR by 15 aborted by reset 3 cycles after accept
    issue(3'b110, 16'h0001, 16'h000F);
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_flags", {flag_z, flag_v, flag_n}, 3'b000);
    tick();
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
      tick();
    end
    chk("abort_no_stale", stale, 0);
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    tick();
    issue(3'b000, 16'h0001, 16'h0001);
    @(negedge clk);
    chk("recover_result", out_result, 16'h0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
